multi_interval_timer: RTL and testbench

Parametrised N-channel interval timer, the successor to the team's single-channel fixed 1 s hold counter. Each channel has its own run-time interval, one-shot or periodic mode, stop and optional retrigger, plus a level `busy` and a one-cycle `done` pulse. It sits between control FSMs and the slow-event logic: LED blink, debounce windows, timeouts and periodic sampling strobes. It runs on the 100 MHz system clock.

---
 rtl/timer_pkg.sv | 22 ++
 rtl/multi_interval_timer_if.sv | 24 ++
 rtl/timer_channel.sv | 90 +++++++++
 rtl/multi_interval_timer.sv | 32 +++
 tb/tb_multi_interval_timer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the multi-channel interval timer.
// Standard limit values assume the 100 MHz system clock.
package timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } timer_state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int unsigned CLK_HZ    = 100_000_000;
  localparam int unsigned TICKS_1S  = 99_999_999;
  localparam int unsigned TICKS_1MS = 99_999;

  // Interval of ms milliseconds expressed as a terminal count (interval = limit+1).
  function automatic int unsigned ms_to_limit(input int unsigned ms);
    return ms * (CLK_HZ / 1000) - 1;
  endfunction

endpackage

// File: rtl/multi_interval_timer_if.sv
// Control/status bundle of the multi-channel interval timer.
// The controller side is the master, the timer is the slave.
interface multi_interval_timer_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 27
);
  logic [N_CH-1:0]       start;
  logic [N_CH-1:0]       stop;
  logic [N_CH-1:0]       mode;
  logic [N_CH*CNT_W-1:0] limit;
  logic [N_CH-1:0]       busy;
  logic [N_CH-1:0]       done;
  logic [N_CH*CNT_W-1:0] count;

  modport master (
    output start, stop, mode, limit,
    input  busy, done, count
  );

  modport slave (
    input  start, stop, mode, limit,
    output busy, done, count
  );
endinterface

// File: rtl/timer_channel.sv
// One interval timer channel: IDLE/RUN state, up-counter and shadowed limit/mode.
// All outputs are flops; nothing combinational reaches the ports.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | stopped, cnt held at 0, waiting for start
// ST_RUN  | counting 0..lim_q; terminal count ends or wraps the interval
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W  = 27,
  parameter bit RETRIG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] limit,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  timer_state_e     state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lim_q;
  logic             mode_q;
  logic             busy_q;
  logic             done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      lim_q  <= '0;
      mode_q <= MODE_ONESHOT;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state  <= ST_IDLE;
        busy_q <= 1'b0;
        cnt    <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            cnt <= '0;
            if (start) begin
              state  <= ST_RUN;
              busy_q <= 1'b1;
              lim_q  <= limit;
              mode_q <= mode;
            end
          end
          ST_RUN: begin
            if (start && RETRIG) begin
              // Retrigger pre-empts a terminal count landing on the same edge.
              cnt    <= '0;
              lim_q  <= limit;
              mode_q <= mode;
            end else if (cnt == lim_q) begin
              cnt    <= '0;
              done_q <= 1'b1;
              if (mode_q == MODE_PERIODIC) begin
                lim_q <= limit;
              end else begin
                state  <= ST_IDLE;
                busy_q <= 1'b0;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
          end
        endcase
      end
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign count = cnt;

endmodule

// File: rtl/multi_interval_timer.sv
// N independent interval timer channels; the top only slices and
// concatenates the per-channel buses.
module multi_interval_timer
  import timer_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 27,
  parameter bit RETRIG = 1'b1
) (
  input logic                    clk,
  input logic                    rst_n,
  multi_interval_timer_if.slave  tif
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timer_channel #(
      .CNT_W  (CNT_W),
      .RETRIG (RETRIG)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .start (tif.start[i]),
      .stop  (tif.stop[i]),
      .mode  (tif.mode[i]),
      .limit (tif.limit[i*CNT_W +: CNT_W]),
      .busy  (tif.busy[i]),
      .done  (tif.done[i]),
      .count (tif.count[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_multi_interval_timer.sv
// Bench for multi_interval_timer: a RETRIG=1 and a RETRIG=0 instance share
// stimulus and are checked every cycle against an interval-phase model.
module tb_multi_interval_timer;
  import timer_pkg::*;

  localparam int N_CH  = 4;
  localparam int CNT_W = 27;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N_CH-1:0]       st = '0;
  logic [N_CH-1:0]       sp = '0;
  logic [N_CH-1:0]       md = '0;
  logic [N_CH*CNT_W-1:0] lim = '0;

  multi_interval_timer_if #(.N_CH(N_CH), .CNT_W(CNT_W)) ifa ();
  multi_interval_timer_if #(.N_CH(N_CH), .CNT_W(CNT_W)) ifb ();

  assign ifa.start = st;
  assign ifa.stop  = sp;
  assign ifa.mode  = md;
  assign ifa.limit = lim;
  assign ifb.start = st;
  assign ifb.stop  = sp;
  assign ifb.mode  = md;
  assign ifb.limit = lim;

  multi_interval_timer #(.N_CH(N_CH), .CNT_W(CNT_W), .RETRIG(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tif(ifa));
  multi_interval_timer #(.N_CH(N_CH), .CNT_W(CNT_W), .RETRIG(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .tif(ifb));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic get_busy(input int d, input int c);
    return (d == 0) ? ifa.busy[c] : ifb.busy[c];
  endfunction
  function automatic logic get_done(input int d, input int c);
    return (d == 0) ? ifa.done[c] : ifb.done[c];
  endfunction
  function automatic logic [CNT_W-1:0] get_count(input int d, input int c);
    return (d == 0) ? ifa.count[c*CNT_W +: CNT_W] : ifb.count[c*CNT_W +: CNT_W];
  endfunction

  // Model: a running channel tracks how far it is into an interval of len cycles.
  bit m_act [2][N_CH];
  bit m_per [2][N_CH];
  bit m_dn  [2][N_CH];
  int m_ph  [2][N_CH];
  int m_len [2][N_CH];

  function automatic int lim_of(input int c);
    return int'(lim[c*CNT_W +: CNT_W]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (!rst_n) begin
          m_act[d][c] = 0; m_per[d][c] = 0; m_dn[d][c] = 0;
          m_ph[d][c] = 0;  m_len[d][c] = 1;
        end else begin
          m_dn[d][c] = 0;
          if (sp[c]) begin
            m_act[d][c] = 0;
            m_ph[d][c]  = 0;
          end else if (st[c] && (!m_act[d][c] || d == 0)) begin
            m_act[d][c] = 1;
            m_ph[d][c]  = 0;
            m_len[d][c] = lim_of(c) + 1;
            m_per[d][c] = md[c];
          end else if (m_act[d][c]) begin
            m_ph[d][c]++;
            if (m_ph[d][c] == m_len[d][c]) begin
              m_dn[d][c] = 1;
              m_ph[d][c] = 0;
              if (m_per[d][c]) m_len[d][c] = lim_of(c) + 1;
              else m_act[d][c] = 0;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < N_CH; c++) begin
        chk($sformatf("busy d%0d c%0d", d, c), 64'(get_busy(d, c)), 64'(m_act[d][c]));
        chk($sformatf("done d%0d c%0d", d, c), 64'(get_done(d, c)), 64'(m_dn[d][c]));
        chk($sformatf("count d%0d c%0d", d, c), 64'(get_count(d, c)), 64'(m_ph[d][c]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lim(input int c, input int v);
    lim[c*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  int nd, p1, p2, first_a, first_b;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(ifa.busy), 0);
    chk("reset count", 64'(ifa.count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // One-shot, limit 4
    set_lim(0, 4); md[0] = MODE_ONESHOT; st[0] = 1'b1;
    step(); st[0] = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      chk("os count", 64'(get_count(0, 0)), (k <= 4) ? 64'(k) : 0);
      chk("os busy", 64'(get_busy(0, 0)), (k <= 4) ? 1 : 0);
      chk("os done", 64'(get_done(0, 0)), (k == 5) ? 1 : 0);
      step();
    end

    // Periodic, limit 2, then 5 from the next wrap
    set_lim(1, 2); md[1] = MODE_PERIODIC; st[1] = 1'b1;
    step(); st[1] = 1'b0;
    nd = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (get_done(0, 1)) nd++;
      chk("per busy", 64'(get_busy(0, 1)), 1);
    end
    chk("per 4 periods", 64'(nd), 4);
    set_lim(1, 5);
    nd = 0; p1 = 0; p2 = 0;
    for (int k = 13; k <= 28; k++) begin
      step();
      if (get_done(1, 1)) begin
        nd++; p1 = p2; p2 = k;
      end
    end
    chk("per reload dones", 64'(nd), 3);
    chk("per new period", 64'(p2 - p1), 6);
    sp[1] = 1'b1; step(); sp[1] = 1'b0;

    // Retrigger at count 6, limit 9
    set_lim(2, 9); md[2] = MODE_ONESHOT; st[2] = 1'b1;
    step(); st[2] = 1'b0;
    repeat (6) step();
    chk("rt pre count", 64'(get_count(0, 2)), 6);
    st[2] = 1'b1; step(); st[2] = 1'b0;
    chk("rt count a", 64'(get_count(0, 2)), 0);
    chk("rt count b", 64'(get_count(1, 2)), 7);
    first_a = -1; first_b = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (get_done(0, 2) && first_a < 0) first_a = k;
      if (get_done(1, 2) && first_b < 0) first_b = k;
    end
    chk("rt done a", 64'(first_a), 10);
    chk("rt done b", 64'(first_b), 3);

    // Stop at count 3, simultaneous start/stop idle and running
    set_lim(3, 7); md[3] = MODE_ONESHOT; st[3] = 1'b1;
    step(); st[3] = 1'b0;
    repeat (3) step();
    chk("stop pre count", 64'(get_count(0, 3)), 3);
    sp[3] = 1'b1; step(); sp[3] = 1'b0;
    chk("stop busy", 64'(get_busy(0, 3)), 0);
    chk("stop count", 64'(get_count(0, 3)), 0);
    st[3] = 1'b1; sp[3] = 1'b1; step(); st[3] = 1'b0; sp[3] = 1'b0;
    chk("ss idle busy", 64'(get_busy(1, 3)), 0);
    st[3] = 1'b1; step(); st[3] = 1'b0; step();
    st[3] = 1'b1; sp[3] = 1'b1; step(); st[3] = 1'b0; sp[3] = 1'b0;
    chk("ss run busy", 64'(get_busy(0, 3)), 0);
    repeat (10) step();

    // limit 0 periodic
    set_lim(0, 0); md[0] = MODE_PERIODIC; st[0] = 1'b1;
    step(); st[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("l0 done", 64'(get_done(0, 0)), 1);
    end
    sp[0] = 1'b1; step(); sp[0] = 1'b0;
    chk("l0 stop done", 64'(get_done(0, 0)), 0);
    chk("l0 stop busy", 64'(get_busy(0, 0)), 0);
    set_lim(0, 3); st[0] = 1'b1;
    step(); st[0] = 1'b0;
    set_lim(0, 0);
    repeat (6) step();
    chk("reload l0 done", 64'(get_done(1, 0)), 1);
    sp[0] = 1'b1; step(); sp[0] = 1'b0;
    chk("reload stop done", 64'(get_done(1, 0)), 0);
    chk("reload stop busy", 64'(get_busy(1, 0)), 0);

    // Skewed starts, then async reset mid-interval
    md = '0;
    for (int c = 0; c < N_CH; c++) begin
      set_lim(c, 20 + 10 * c); st[c] = 1'b1; step(); st[c] = 1'b0;
      repeat (2) step();
    end
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", 64'(ifa.busy | ifb.busy), 0);
    chk("arst done", 64'(ifa.done | ifb.done), 0);
    chk("arst count", 64'(|(ifa.count | ifb.count)), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post rst idle", 64'(ifa.busy | ifb.busy), 0);
    end
    md = '1;
    for (int c = 0; c < N_CH; c++) begin
      set_lim(c, 3 + 2 * c); st[c] = 1'b1; step(); st[c] = 1'b0;
    end
    repeat (60) step();
    sp = '1; step(); sp = '0;

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N_CH; c++) begin
        st[c] = ($urandom_range(7) == 0);
        sp[c] = ($urandom_range(31) == 0);
        md[c] = $urandom_range(1);
        if ($urandom_range(3) == 0) set_lim(c, $urandom_range(15));
      end
      step();
    end
    st = '0; sp = '0;
    repeat (40) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
